// File: rtl/scoreboard_pkg.sv
// Shared definitions for the pipeline register scoreboard.
// Contents:
//   clog2        - ceiling log2 used to size address/unit/latency fields
//   DEF_*        - default configuration constants
//   sb_entry_t   - one scoreboard entry (pending, unit, stage row) at the
//                  default configuration widths
package scoreboard_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int DEF_NREGS  = 32;
  localparam int DEF_NUNITS = 4;
  localparam int DEF_DEPTH  = 5;
  localparam int DEF_NRD    = 2;
  localparam int DEF_UW     = clog2(DEF_NUNITS);

  typedef struct packed {
    logic                 pending;
    logic [DEF_UW-1:0]    unit;
    logic [DEF_DEPTH-1:0] row;
  } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Bus between the issue stage and the scoreboard.
// master (issue stage): drives lookup addresses, claim request, freeze, flush;
//                       receives lookup results, iss_waw and any_pending.
// slave  (scoreboard) : the mirror image.
interface pipe_scoreboard_if
  import scoreboard_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int NUNITS = DEF_NUNITS,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = DEF_NRD
);
  localparam int AW = clog2(NREGS);
  localparam int UW = clog2(NUNITS);
  localparam int LW = clog2(DEPTH + 1);

  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD-1:0]       rd_pending;
  logic [NRD*UW-1:0]    rd_unit;
  logic [NRD*DEPTH-1:0] rd_row;
  logic                 iss_valid;
  logic [AW-1:0]        iss_addr;
  logic [UW-1:0]        iss_unit;
  logic [LW-1:0]        iss_lat;
  logic                 iss_waw;
  logic                 freeze;
  logic                 flush;
  logic                 any_pending;

  modport master (
    output rd_addr, iss_valid, iss_addr, iss_unit, iss_lat, freeze, flush,
    input  rd_pending, rd_unit, rd_row, iss_waw, any_pending
  );

  modport slave (
    input  rd_addr, iss_valid, iss_addr, iss_unit, iss_lat, freeze, flush,
    output rd_pending, rd_unit, rd_row, iss_waw, any_pending
  );
endinterface

// File: rtl/sb_entry.sv
// One scoreboard row: pending flag, producing unit and a one-hot stage row
// that walks right once per unfrozen cycle until it falls off the end.
// Ports:
//   clock, reset (async, active-low)
//   i_load   - accept a new claim (wins over the shift/expiry this edge)
//   i_unit   - producing unit for the claim
//   i_row    - one-hot row to load
//   i_freeze - hold state
//   i_flush  - clear state (wins over freeze and load)
//   o_pending, o_unit, o_row - current entry contents
module sb_entry
  import scoreboard_pkg::*;
#(
  parameter int UW    = 2,
  parameter int DEPTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [UW-1:0]    i_unit,
  input  logic [DEPTH-1:0] i_row,
  input  logic             i_freeze,
  input  logic             i_flush,
  output logic             o_pending,
  output logic [UW-1:0]    o_unit,
  output logic [DEPTH-1:0] o_row
);
  logic             r_pending;
  logic [UW-1:0]    r_unit;
  logic [DEPTH-1:0] r_row;
  logic [DEPTH-1:0] w_shifted;

  assign w_shifted = r_row >> 1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
      r_unit    <= '0;
      r_row     <= '0;
    end else if (i_flush) begin
      r_pending <= 1'b0;
      r_unit    <= '0;
      r_row     <= '0;
    end else if (!i_freeze) begin
      if (i_load) begin
        r_pending <= 1'b1;
        r_unit    <= i_unit;
        r_row     <= i_row;
      end else if (w_shifted == '0) begin
        // Result has left the last stage: entry retires this edge.
        r_pending <= 1'b0;
        r_unit    <= '0;
        r_row     <= '0;
      end else begin
        r_row <= w_shifted;
      end
    end
  end

  // Unit and row are already cleared on retirement; the mask keeps a
  // non-pending entry reading zero even if that ever changes.
  assign o_pending = r_pending;
  assign o_unit    = r_pending ? r_unit : '0;
  assign o_row     = r_pending ? r_row  : '0;
endmodule

// File: rtl/pipe_scoreboard.sv
// Register scoreboard for an in-order pipeline. Tracks which architectural
// registers await a result, which unit produces it and how far along it is.
// Ports:
//   clock, reset (async, active-low)
//   bus (slave) - lookup ports rd_*, claim port iss_*, freeze, flush,
//                 iss_waw hazard flag, any_pending summary
module pipe_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int NUNITS = DEF_NUNITS,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = DEF_NRD
) (
  input  logic               clock,
  input  logic               reset,
  pipe_scoreboard_if.slave   bus
);
  localparam int AW = clog2(NREGS);
  localparam int UW = clog2(NUNITS);
  localparam int LW = clog2(DEPTH + 1);

  logic             w_pending [NREGS];
  logic [UW-1:0]    w_unit    [NREGS];
  logic [DEPTH-1:0] w_row     [NREGS];

  logic [LW-1:0]    w_lat_clamped;
  logic [LW-1:0]    w_lat_m1;
  logic [DEPTH-1:0] w_load_row;
  logic             w_accept;
  logic [DEPTH-1:0] w_sel_row;

  assign w_lat_clamped = (bus.iss_lat > LW'(DEPTH)) ? LW'(DEPTH) : bus.iss_lat;
  assign w_lat_m1      = w_lat_clamped - LW'(1);
  assign w_load_row    = DEPTH'(1) << w_lat_m1;
  assign w_accept      = bus.iss_valid && !bus.freeze && !bus.flush &&
                         (bus.iss_addr != '0) && (bus.iss_lat != '0);

  // Register 0 is hard-wired: never pending.
  assign w_pending[0] = 1'b0;
  assign w_unit[0]    = '0;
  assign w_row[0]     = '0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_entry
    sb_entry #(.UW(UW), .DEPTH(DEPTH)) u_entry (
      .clock     (clock),
      .reset     (reset),
      .i_load    (w_accept && (bus.iss_addr == AW'(gi))),
      .i_unit    (bus.iss_unit),
      .i_row     (w_load_row),
      .i_freeze  (bus.freeze),
      .i_flush   (bus.flush),
      .o_pending (w_pending[gi]),
      .o_unit    (w_unit[gi]),
      .o_row     (w_row[gi])
    );
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr                          = bus.rd_addr[gi*AW +: AW];
    assign bus.rd_pending[gi]              = w_pending[w_addr];
    assign bus.rd_unit[gi*UW +: UW]        = w_unit[w_addr];
    assign bus.rd_row[gi*DEPTH +: DEPTH]   = w_row[w_addr];
  end

  // WAW: the new result would land no later than the one already in
  // flight, i.e. the existing row has a bit at or above the new stage
  // index. A zero latency would sit below every stage.
  assign w_sel_row   = w_row[bus.iss_addr];
  assign bus.iss_waw = bus.iss_valid && (bus.iss_addr != '0) &&
                       w_pending[bus.iss_addr] &&
                       ((w_lat_clamped == '0) || ((w_sel_row >> w_lat_m1) != '0));

  always_comb begin
    bus.any_pending = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      bus.any_pending = bus.any_pending | w_pending[i];
    end
  end
endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of tracked architectural registers (power of two, >=2).
REQ-002 SHALL have parameter NUNITS, default 4, number of functional units (>=2).
REQ-003 SHALL have parameter DEPTH, default 5, width of each row's one-hot stage vector (>=2).
REQ-004 SHALL have parameter NRD, default 2, number of lookup ports.
REQ-005 SHALL have derived widths AW=clog2(NREGS), UW=clog2(NUNITS), LW=clog2(DEPTH+1).
REQ-006 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rd_addr  input  NRD*AW  lookup register addresses; port k occupies bits [k*AW +: AW].
REQ-009 SHALL have port rd_pending  output  NRD  per-port pending flag.
REQ-010 SHALL have port rd_unit  output  NRD*UW  per-port producing unit.
REQ-011 SHALL have port rd_row  output  NRD*DEPTH  per-port stage vector.
REQ-012 SHALL have port iss_valid  input  1  claim request from issue stage.
REQ-013 SHALL have port iss_addr  input  AW  destination register to claim.
REQ-014 SHALL have port iss_unit  input  UW  unit producing the result.
REQ-015 SHALL have port iss_lat  input  LW  cycles until the result is available.
REQ-016 SHALL have port iss_waw  output  1  the claim would complete no later than the existing pending write to iss_addr.
REQ-017 SHALL have port freeze  input  1  pipeline stall; hold all rows.
REQ-018 SHALL have port flush  input  1  squash all pending entries.
REQ-019 SHALL have port any_pending  output  1  OR of all pending flags.

Function
REQ-020 SHALL hold one entry per register: pending bit, UW-bit unit field, DEPTH-bit row.
REQ-021 SHALL drive lookup outputs combinationally from current state; a non-pending entry reads unit=0 and row=0 (never X or Z).
REQ-022 SHALL treat register 0 as constant: never pending, and claims to address 0 are ignored.
REQ-023 SHALL, on each edge with freeze=0 and flush=0, shift every row right by one and clear pending and unit on every entry whose shifted row is zero.
REQ-024 SHALL, on an accepted claim, load the row with 1<<(iss_lat-1), set pending, and write iss_unit.
REQ-025 SHALL accept a claim only when iss_valid=1, freeze=0, flush=0, iss_addr!=0 and iss_lat!=0.
REQ-026 SHALL clamp iss_lat>DEPTH to DEPTH.
REQ-027 SHALL keep a claimed entry pending for exactly min(iss_lat,DEPTH) cycles after the claim edge, provided it is not frozen or flushed.
REQ-028 SHALL give a claim priority over the same-cycle shift or expiry of the same entry; the new value replaces the old one.
REQ-029 SHALL, when freeze=1 and flush=0, leave all state unchanged and ignore claims.
REQ-030 SHALL, when flush=1, clear all entries at the edge regardless of freeze or iss_valid.
REQ-031 SHALL assert iss_waw combinationally when iss_valid=1, iss_addr!=0, the entry is pending, and its highest set row bit index >= clamped iss_lat-1; otherwise iss_waw=0.
REQ-032 SHALL still accept a claim while iss_waw=1; stalling on it is the issue stage's decision.

Reset
REQ-033 SHALL, while reset=0, clear all entries, giving rd_pending=0, rd_unit=0, rd_row=0, iss_waw=0 and any_pending=0.
REQ-034 SHALL discard in-flight claims on reset assertion mid-operation; after reset release the first edge may accept a claim.

Structure
REQ-035 SHALL place the entry record typedef, the clog2 helper and the default parameter constants in a shared package scoreboard_pkg.
REQ-036 SHALL implement each row as sub-module sb_entry (pending, unit and shift row with load/freeze/flush), instantiated NREGS-1 times; address 0 is tied off.

Verification
REQ-037 SHALL cover: claim r5, unit 2, lat 3 -> pending for exactly 3 cycles; rd_row 100,010,001 (DEPTH=3 view) then 0.
REQ-038 SHALL cover: freeze=1 for 2 cycles during the r5 lat-3 window -> pending for 5 cycles and row held during the freeze.
REQ-039 SHALL cover: claim r7 lat 1 on the edge an older r7 expires -> r7 pending one more cycle with the new unit.
REQ-040 SHALL cover: r9 pending with row bit 3 set, claim r9 lat 2 -> iss_waw=1; claim r9 lat 5 -> iss_waw=0.
REQ-041 SHALL cover: flush=1 with iss_valid=1 while 6 entries are pending -> all clear next cycle and any_pending=0.
REQ-042 SHALL cover: claim r0 and claim lat 0 -> no state change; reset asserted mid-window -> all outputs 0 immediately.
